exe_mem_pipe_stage: RTL

//  Parametrised EXE->MEM pipeline register with a valid/ready handshake, a 2-entry skid buffer,

---
 rtl/exe_mem_pipe_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/exe_mem_pipe_stage.sv
// EXE->MEM pipeline register with valid/ready handshake and a 2-entry skid buffer.
// The main entry drives the MEM side. The skid entry absorbs one back-pressure cycle.
module exe_mem_pipe_stage #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WIDE_W      = 64,
    parameter int unsigned REGWR_W     = 32,
    parameter int unsigned WB_CTRL_W   = 10,
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   Flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDE_W-1:0]      OUT_ALU64,
    input  logic [DATA_W-1:0]      OUT_ALU32,
    input  logic [WIDE_W-1:0]      Rt_data64_EXE,
    input  logic [DATA_W-1:0]      Rt_data_EXE,
    input  logic [DATA_W-1:0]      Rs_data_EXE,
    input  logic [REGWR_W-1:0]     RegWr_EXE,
    input  logic [WB_CTRL_W-1:0]   WB_control_EX,
    input  logic [2:0]             MEM_control_EX,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDE_W-1:0]      OUT_ALU64_MEM,
    output logic [DATA_W-1:0]      Adrs_MEM,
    output logic [WIDE_W-1:0]      Rt_data64_MEM,
    output logic [DATA_W-1:0]      Rt_data_MEM,
    output logic [DATA_W-1:0]      HILO_write_MEM,
    output logic [REGWR_W-1:0]     RegWr_MEM,
    output logic [WB_CTRL_W-1:0]   WB_control_MEM,
    output logic                   MemRead,
    output logic                   MemWrite,
    output logic                   MemWrite64,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    typedef struct packed {
        logic [WIDE_W-1:0]    alu64;
        logic [DATA_W-1:0]    alu32;
        logic [WIDE_W-1:0]    rt64;
        logic [DATA_W-1:0]    rt;
        logic [DATA_W-1:0]    rs;
        logic [REGWR_W-1:0]   regwr;
        logic [WB_CTRL_W-1:0] wb;
        logic [2:0]           mem;
    } entry_t;

    entry_t in_e;
    entry_t m_d, m_q, s_d, s_q;
    logic   m_v_d, m_v_q, s_v_d, s_v_q;
    logic   accept;
    logic [STALL_CNT_W-1:0] stall_d, stall_q;

    localparam logic [STALL_CNT_W-1:0] StallOne = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        in_e.alu64 = OUT_ALU64;
        in_e.alu32 = OUT_ALU32;
        in_e.rt64  = Rt_data64_EXE;
        in_e.rt    = Rt_data_EXE;
        in_e.rs    = Rs_data_EXE;
        in_e.regwr = RegWr_EXE;
        in_e.wb    = WB_control_EX;
        in_e.mem   = MEM_control_EX;
    end

    // in_ready depends only on registered state, so out_ready never reaches it.
    assign in_ready = !s_v_q;
    assign accept   = in_valid && in_ready;

    always_comb begin
        m_d     = m_q;
        s_d     = s_q;
        m_v_d   = m_v_q;
        s_v_d   = s_v_q;
        stall_d = stall_q;

        if (m_v_q && !out_ready && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + StallOne;
        end

        if (Flush) begin
            m_v_d = 1'b0;
            s_v_d = 1'b0;
        end else if (!m_v_q || out_ready) begin
            if (s_v_q) begin
                // Skid entry is older than any new input; it moves up first.
                m_d   = s_q;
                m_v_d = 1'b1;
                s_v_d = accept;
                if (accept) begin
                    s_d = in_e;
                end
            end else begin
                m_v_d = accept;
                if (accept) begin
                    m_d = in_e;
                end
            end
        end else if (accept) begin
            s_d   = in_e;
            s_v_d = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            m_q     <= '0;
            s_q     <= '0;
            m_v_q   <= 1'b0;
            s_v_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            m_q     <= m_d;
            s_q     <= s_d;
            m_v_q   <= m_v_d;
            s_v_q   <= s_v_d;
            stall_q <= stall_d;
        end
    end

    assign out_valid      = m_v_q;
    assign OUT_ALU64_MEM  = m_q.alu64;
    assign Adrs_MEM       = m_q.alu32;
    assign Rt_data64_MEM  = m_q.rt64;
    assign Rt_data_MEM    = m_q.rt;
    assign HILO_write_MEM = m_q.rs;
    assign RegWr_MEM      = m_q.regwr;
    assign WB_control_MEM = m_v_q ? m_q.wb : '0;
    assign MemRead        = m_v_q && m_q.mem[2];
    assign MemWrite       = m_v_q && m_q.mem[1];
    assign MemWrite64     = m_v_q && m_q.mem[0];
    assign stall_cycles   = stall_q;

endmodule
